// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and counter sizing.
package serial_adder_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_SHIFT = SHIFT,
        ST_DONE  = DONE
    } state_e;

    // Bit counter width: max(1, clog2(width)) so WIDTH=1 still gets a real flop.
    function automatic int cnt_width(input int width);
        if ($clog2(width) < 1) begin
            return 1;
        end else begin
            return $clog2(width);
        end
    endfunction

endpackage

// File: rtl/adder1.sv
// One-bit full adder cell; purely combinational.
module adder1 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one adder1 cell, registered carry, LSB-first shifting,
// one-cycle done pulse when sum/cout are valid.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_sum_s;
    logic             fa_cout_s;
    logic [WIDTH-1:0] sum_shift_s;

    adder1 u_adder1 (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum_s),
        .cout (fa_cout_s)
    );

    // New result bit enters at the MSB; a one-bit adder has nothing to shift down.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign sum_shift_s = fa_sum_s;
        end else begin : g_sum_wn
            assign sum_shift_s = {fa_sum_s, sum_q[WIDTH-1:1]};
        end
    endgenerate

    // Next-state, datapath and output-flag computation.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    sum_d   = {WIDTH{1'b0}};
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                sum_d   = sum_shift_s;
                a_d     = a_q >> 1'b1;
                b_d     = b_q >> 1'b1;
                carry_d = fa_cout_s;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Flags are flopped from the next state so outputs come straight off registers.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 and WIDTH=1 instances, table vectors,
// hand-written corner sequences and randomized operands against an arithmetic model.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start8 = 1'b0;
    logic [7:0] a8 = 8'h00, b8 = 8'h00;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;
    logic       start1 = 1'b0;
    logic [0:0] a1 = 1'b0, b1 = 1'b0;
    logic       cin1 = 1'b0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=8 operation; pulse_at>0 raises start (with other operands) for one cycle mid-SHIFT.
    task automatic op8(input logic [7:0] a_i, input logic [7:0] b_i, input logic c_i,
                       input logic [7:0] es, input logic ec, input int pulse_at, input string tag);
        int done_edge;
        int done_cnt;
        int busy_cnt;
        a8 = a_i; b8 = b_i; cin8 = c_i; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        done_edge = -1; done_cnt = 0; busy_cnt = busy8 ? 1 : 0;
        for (int e = 1; e <= 14; e++) begin
            if (e == pulse_at) begin
                start8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
            end
            tick();
            start8 = 1'b0;
            if (busy8) busy_cnt++;
            if (done8) begin
                done_cnt++;
                if (done_edge < 0) begin
                    done_edge = e;
                    check({tag, " sum@done"}, 64'(sum8), 64'(es));
                    check({tag, " cout@done"}, 64'(cout8), 64'(ec));
                end
            end
        end
        check({tag, " done_edge"}, 64'(done_edge), 64'd8);
        check({tag, " done_count"}, 64'(done_cnt), 64'd1);
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd9);
        check({tag, " sum_held"}, 64'({cout8, sum8}), 64'({ec, es}));
    endtask

    vec_t vecs[5];
    logic [8:0] model;
    int seen_idle, second_acc, dcnt;
    logic [1:0] m1;

    initial begin
        vecs[0] = '{a: 8'hA5, b: 8'h5A, cin: 1'b0, exp_sum: 8'hFF, exp_cout: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, exp_sum: 8'h00, exp_cout: 1'b1};
        vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, exp_sum: 8'hFF, exp_cout: 1'b1};
        vecs[3] = '{a: 8'h00, b: 8'h00, cin: 1'b1, exp_sum: 8'h01, exp_cout: 1'b0};
        vecs[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, exp_sum: 8'h00, exp_cout: 1'b1};

        // Reset with random inputs, then release with start low.
        rst = 1'b1; start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'b1;
        tick(); tick();
        check("rst busy", 64'(busy8), 64'd0);
        check("rst done", 64'(done8), 64'd0);
        check("rst sum", 64'(sum8), 64'h00);
        check("rst cout", 64'(cout8), 64'd0);
        rst = 1'b0; start8 = 1'b0;
        tick(); tick(); tick();
        check("post-rst idle", 64'({busy8, done8, cout8, sum8}), 64'd0);

        for (int i = 0; i < 5; i++)
            op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout, 0, $sformatf("vec%0d", i));
        tick();

        // Start pulse mid-SHIFT must not disturb or queue.
        op8(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 3, "ignored_start");
        tick();

        // Start held high: re-accept on the first IDLE edge, k+10.
        a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
        tick();
        seen_idle = -1; second_acc = -1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (!busy8 && seen_idle < 0) seen_idle = e;
            if (seen_idle >= 0 && busy8 && second_acc < 0) second_acc = e;
        end
        start8 = 1'b0;
        check("held idle_edge", 64'(seen_idle), 64'd9);
        check("held reaccept_edge", 64'(second_acc), 64'd10);
        for (int e = 0; e < 20 && busy8; e++) tick();
        check("held result", 64'({cout8, sum8}), 64'h033);
        check("held quiesce", 64'(busy8), 64'd0);

        // Reset at edge k+4 aborts with no done pulse.
        a8 = 8'h77; b8 = 8'h99; cin8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        check("abort outputs", 64'({busy8, done8, cout8, sum8}), 64'd0);
        rst = 1'b0;
        dcnt = 0;
        for (int e = 0; e < 12; e++) begin
            tick();
            if (done8) dcnt++;
        end
        check("abort no_done", 64'(dcnt), 64'd0);
        op8(8'h03, 8'h04, 1'b1, 8'h08, 1'b0, 0, "after_abort");
        tick();

        // Random operands against plain arithmetic.
        for (int i = 0; i < 25; i++) begin
            logic [7:0] ra, rb;
            logic rc;
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            model = 9'(ra) + 9'(rb) + 9'(rc);
            op8(ra, rb, rc, model[7:0], model[8], 0, $sformatf("rand%0d", i));
            if ($urandom_range(1, 0) == 1) tick();
        end

        // WIDTH=1: every combination, done one edge after acceptance.
        for (int i = 0; i < 8; i++) begin
            int de;
            logic [2:0] combo;
            combo = 3'(i);
            a1 = combo[0]; b1 = combo[1]; cin1 = combo[2];
            m1 = 2'(combo[0]) + 2'(combo[1]) + 2'(combo[2]);
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            de = -1;
            for (int e = 1; e <= 5; e++) begin
                tick();
                if (done1 && de < 0) begin
                    de = e;
                    check($sformatf("w1 %0d result", i), 64'({cout1, sum1}), 64'(m1));
                end
            end
            check($sformatf("w1 %0d done_edge", i), 64'(de), 64'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
